// File: rtl/mul_seq_ctrl.sv
// Control sequencer for a shift-and-add multiplier datapath: one registered
// control word per clock, start/busy/done handshake, abort and sign-magnitude mode.
module mul_seq_ctrl #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       op_signed,
    input  logic       abort,
    input  logic       p_b0,
    input  logic       p_zero,
    input  logic       p_sign,
    output logic [7:0] y,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(N + 1);

    localparam int Y_LD_A    = 0;
    localparam int Y_LD_B    = 1;
    localparam int Y_CLR_ACC = 2;
    localparam int Y_ABS     = 3;
    localparam int Y_ADD     = 4;
    localparam int Y_SHR     = 5;
    localparam int Y_NEG     = 6;
    localparam int Y_LD_RES  = 7;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        CHECK,
        TEST,
        ADD,
        SHIFT,
        CORR,
        FIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sgn_q, sgn_d;
    logic            smode_q, smode_d;
    logic            err_q, err_d;
    logic [7:0]      y_q, y_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        smode_d = smode_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                smode_d = op_signed;
                if (start) begin
                    state_d = LOAD;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                cnt_d   = CW'(N);
                sgn_d   = p_sign & smode_q;
                state_d = CHECK;
            end
            CHECK:   state_d = p_zero ? FIN : TEST;
            TEST: begin
                if (cnt_q == '0)  state_d = sgn_q ? CORR : FIN;
                else if (p_b0)    state_d = ADD;
                else              state_d = SHIFT;
            end
            ADD:     state_d = SHIFT;
            SHIFT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = TEST;
            end
            CORR:    state_d = FIN;
            FIN:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever transition the sequence would have taken.
        if (abort && busy_q) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    // Outputs are decoded from the next state so the registered word lines up
    // with the cycle the machine actually spends in that state.
    always_comb begin
        y_d = '0;
        case (state_d)
            LOAD: begin
                y_d[Y_LD_A]    = 1'b1;
                y_d[Y_LD_B]    = 1'b1;
                y_d[Y_CLR_ACC] = 1'b1;
                y_d[Y_ABS]     = smode_d;
            end
            ADD:     y_d[Y_ADD]    = 1'b1;
            SHIFT:   y_d[Y_SHR]    = 1'b1;
            CORR:    y_d[Y_NEG]    = 1'b1;
            FIN:     y_d[Y_LD_RES] = 1'b1;
            default: y_d = '0;
        endcase
        busy_d = !(state_d == IDLE || state_d == DONE);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            smode_q <= 1'b0;
            err_q   <= 1'b0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            smode_q <= smode_d;
            err_q   <= err_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: a small behavioural datapath answers the
// controller's flags and control words; traces and latencies are hand-derived.
module tb_mul_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic       op_signed = 1'b0;
    logic       abort = 1'b0;
    logic       p_b0;
    logic       p_zero;
    logic       p_sign;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    mul_seq_ctrl #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_signed (op_signed),
        .abort     (abort),
        .p_b0      (p_b0),
        .p_zero    (p_zero),
        .p_sign    (p_sign),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural datapath driven by the control word
    int op_a = 0, op_b = 0;
    int ra, rb, acc, it, res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= 0; rb <= 0; acc <= 0; it <= 0; res <= 0;
        end else begin
            if (y[0]) ra <= (y[3] && op_a < 0) ? -op_a : op_a;
            if (y[1]) rb <= (y[3] && op_b < 0) ? -op_b : op_b;
            if (y[2]) begin acc <= 0; it <= 0; end
            if (y[4]) acc <= acc + (ra << it);
            if (y[5]) begin rb <= rb >>> 1; it <= it + 1; end
            if (y[6]) acc <= -acc;
            if (y[7]) res <= acc;
        end
    end

    assign p_b0   = rb[0];
    assign p_zero = (ra == 0) || (rb == 0);
    assign p_sign = (op_a < 0) ^ (op_b < 0);

    logic [7:0] exp_u [1:23] = '{8'h07, 8'h00, 8'h00, 8'h10, 8'h20, 8'h00, 8'h20, 8'h00,
                                 8'h10, 8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h20,
                                 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h80, 8'h00};
    logic [7:0] exp_s [1:24] = '{8'h0F, 8'h00, 8'h00, 8'h10, 8'h20, 8'h00, 8'h20, 8'h00,
                                 8'h10, 8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h20,
                                 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h40, 8'h80, 8'h00};

    logic [7:0] ytr [0:63];
    int done_cyc, n_neg, n_both, n_busy_bad, n_ldres;
    logic err_c1;

    task automatic run_op(input int a, input int b, input logic sm, input int budget);
        @(negedge clk);
        op_a = a; op_b = b; op_signed = sm; start = 1'b1;
        @(posedge clk);
        done_cyc = -1; n_neg = 0; n_both = 0; n_busy_bad = 0; n_ldres = 0; err_c1 = 1'bx;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) begin start = 1'b0; err_c1 = err; end
            ytr[c] = y;
            if (y[6]) n_neg++;
            if (y[7]) n_ldres++;
            if (y[4] && y[5]) n_both++;
            if (busy === done) n_busy_bad++;
            if (done) begin done_cyc = c; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({y, busy, done, err} !== 11'b0) begin
            errors++; $display("FAIL reset_outputs: got y=%h busy=%b done=%b err=%b expected all 0", y, busy, done, err);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b1;
        @(negedge clk); @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({y, busy, done, err} !== 11'b0) begin
            errors++; $display("FAIL idle_abort: got y=%h busy=%b done=%b err=%b expected all 0", y, busy, done, err);
        end
    endtask

    task automatic test_unsigned();
        int bad, first;
        run_op(3, 5, 1'b0, 40);
        checks++;
        if (done_cyc !== 23) begin errors++; $display("FAIL u_latency: got %0d expected 23", done_cyc); end
        bad = 0; first = -1;
        for (int c = 1; c <= 23; c++) if (ytr[c] !== exp_u[c]) begin bad++; if (first < 0) first = c; end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL u_trace: %0d cycles differ, first at cycle %0d got %h expected %h", bad, first, ytr[first], exp_u[first]);
        end
        checks++;
        if (res !== 15) begin errors++; $display("FAIL u_result: got %0d expected 15", res); end
        checks++;
        if (n_busy_bad != 0 || n_both != 0 || n_ldres != 1) begin
            errors++; $display("FAIL u_flags: busy_bad=%0d add_shr_both=%0d ldres=%0d expected 0 0 1", n_busy_bad, n_both, n_ldres);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL u_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_signed();
        int bad, first;
        run_op(-3, 5, 1'b1, 40);
        checks++;
        if (done_cyc !== 24) begin errors++; $display("FAIL s_latency: got %0d expected 24", done_cyc); end
        bad = 0; first = -1;
        for (int c = 1; c <= 24; c++) if (ytr[c] !== exp_s[c]) begin bad++; if (first < 0) first = c; end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL s_trace: %0d cycles differ, first at cycle %0d got %h expected %h", bad, first, ytr[first], exp_s[first]);
        end
        checks++;
        if (res !== -15 || n_neg != 1) begin
            errors++; $display("FAIL s_result: got res=%0d neg=%0d expected -15 1", res, n_neg);
        end
    endtask

    task automatic test_zero();
        run_op(0, -5, 1'b1, 40);
        checks++;
        if (done_cyc !== 4) begin errors++; $display("FAIL z_latency: got %0d expected 4", done_cyc); end
        checks++;
        if (ytr[1] !== 8'h0F || ytr[2] !== 8'h00 || ytr[3] !== 8'h80 || n_neg != 0) begin
            errors++; $display("FAIL z_trace: got %h %h %h neg=%0d expected 0f 00 80 neg=0", ytr[1], ytr[2], ytr[3], n_neg);
        end
        checks++;
        if (res !== 0) begin errors++; $display("FAIL z_result: got %0d expected 0", res); end
    endtask

    task automatic test_abort();
        int n_shift, seen_done;
        logic hit;
        hit = 1'b0; n_shift = 0; seen_done = 0;
        @(negedge clk);
        op_a = 3; op_b = 5; op_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (y == 8'h20) n_shift++;
            if (n_shift == 3) begin abort = 1'b1; hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL ab_reach: third SHIFT not seen, got %0d shifts expected 3", n_shift); end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (y !== 8'h00 || busy !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL ab_state: got y=%h busy=%b err=%b done=%b expected 00 0 1 0", y, busy, err, done);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done != 0 || err !== 1'b1) begin
            errors++; $display("FAIL ab_idle: got activity=%0d err=%b expected 0 1", seen_done, err);
        end
        run_op(3, 5, 1'b0, 40);
        checks++;
        if (err_c1 !== 1'b0 || done_cyc !== 23 || err !== 1'b0 || res !== 15) begin
            errors++; $display("FAIL ab_restart: got err_c1=%b done_cyc=%0d err=%b res=%0d expected 0 23 0 15", err_c1, done_cyc, err, res);
        end
    endtask

    task automatic test_reset_mid();
        logic hit;
        hit = 1'b0;
        @(negedge clk);
        op_a = 3; op_b = 5; op_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (y == 8'h10) begin hit = 1'b1; break; end
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (!hit || {y, busy, done, err} !== 11'b0) begin
            errors++; $display("FAIL rst_async: got hit=%b y=%h busy=%b done=%b err=%b expected 1 00 0 0 0", hit, y, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_release: got busy=%b done=%b expected 0 0", busy, done);
        end
        run_op(3, 5, 1'b0, 40);
        checks++;
        if (done_cyc !== 23 || res !== 15) begin
            errors++; $display("FAIL rst_rerun: got done_cyc=%0d res=%0d expected 23 15", done_cyc, res);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, n_done, n_load;
        logic [7:0] y24, y25;
        logic b24;
        d1 = -1; d2 = -1; n_done = 0; n_load = 0;
        y24 = 8'hxx; y25 = 8'hxx; b24 = 1'bx;
        @(negedge clk);
        op_a = 3; op_b = 5; op_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            if (c == 48) start = 1'b0;
            if (y == 8'h07) n_load++;
            if (c == 24) begin y24 = y; b24 = busy; end
            if (c == 25) y25 = y;
            if (done) begin
                n_done++;
                if (d1 < 0) d1 = c; else d2 = c;
            end
        end
        checks++;
        if (d1 !== 23 || d2 !== 47 || n_done != 2) begin
            errors++; $display("FAIL b2b_done: got %0d %0d count=%0d expected 23 47 2", d1, d2, n_done);
        end
        checks++;
        if (y24 !== 8'h00 || b24 !== 1'b0 || y25 !== 8'h07) begin
            errors++; $display("FAIL b2b_gap: got y24=%h busy24=%b y25=%h expected 00 0 07", y24, b24, y25);
        end
        checks++;
        if (n_load != 2) begin errors++; $display("FAIL b2b_loads: got %0d expected 2", n_load); end
        @(negedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: got busy=%b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
